// File: rtl/dino_pkg.sv
// Shared constants for the dinosaur game sprite path: sprite geometry,
// screen size and the sprite-image ids stored in the sprite ROM.
package dino_pkg;
  localparam int SPR_W = 16;
  localparam int SPR_H = 16;
  localparam int ID_W  = 3;
  localparam int ROW_W = 9;
  localparam int COL_W = 10;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;

  typedef enum logic [ID_W-1:0] {
    DINO_RUN0 = 3'd0,
    DINO_RUN1 = 3'd1,
    DINO_JUMP = 3'd2,
    CACTUS_S  = 3'd3,
    CACTUS_L  = 3'd4,
    BIRD      = 3'd5
  } spr_id_e;
endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: holds the bitmap row and x position snapshotted for the
// current line and reports whether the current column lands on a set pixel.
module sprite_slot
  import dino_pkg::*;
#(
  parameter int SPR_W = dino_pkg::SPR_W
) (
  input  logic             vga_clk,
  input  logic             clrn,
  input  logic             i_load,
  input  logic             i_hit,
  input  logic [SPR_W-1:0] i_rom_data,
  input  logic [COL_W-1:0] i_x,
  input  logic [COL_W-1:0] i_col,
  output logic             o_px
);
  localparam int LW = $clog2(SPR_W);

  logic [SPR_W-1:0] r_mask;
  logic [COL_W-1:0] r_x;
  logic [COL_W:0]   w_col_ext;
  logic [COL_W:0]   w_x_ext;
  logic [LW-1:0]    w_dx;
  logic [LW-1:0]    w_idx;
  logic             w_in;

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_mask <= '0;
      r_x    <= '0;
    end else if (i_load) begin
      r_mask <= i_hit ? i_rom_data : '0;
      r_x    <= i_x;
    end
  end

  // Compare one bit wider than the column so a sprite near the right edge clips instead of wrapping.
  assign w_col_ext = {1'b0, i_col};
  assign w_x_ext   = {1'b0, r_x};
  assign w_in      = (w_col_ext >= w_x_ext) && (w_col_ext < w_x_ext + (COL_W+1)'(SPR_W));
  assign w_dx      = i_col[LW-1:0] - r_x[LW-1:0];
  assign w_idx     = LW'(SPR_W-1) - w_dx;
  assign o_px      = w_in && r_mask[w_idx];
endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite fetch scheduler: on each hsync fall it reads one ROM row
// per slot into the slot buffers, then ORs the slots into px_sprite and flags collisions.
module sprite_line_scheduler
  import dino_pkg::*;
#(
  parameter int NUM_SPR = 4,
  parameter int SPR_W   = dino_pkg::SPR_W,
  parameter int SPR_H   = dino_pkg::SPR_H,
  parameter int ID_W    = dino_pkg::ID_W,
  localparam int LH     = $clog2(SPR_H)
) (
  input  logic                    vga_clk,
  input  logic                    clrn,
  input  logic                    hs,
  input  logic                    rdn,
  input  logic [ROW_W-1:0]        row_addr,
  input  logic [COL_W-1:0]        col_addr,
  input  logic [NUM_SPR-1:0]      spr_en,
  input  logic [NUM_SPR*COL_W-1:0] spr_x,
  input  logic [NUM_SPR*ROW_W-1:0] spr_y,
  input  logic [NUM_SPR*ID_W-1:0] spr_id,
  output logic                    rom_en,
  output logic [ID_W+LH-1:0]      rom_addr,
  input  logic [SPR_W-1:0]        rom_data,
  input  logic                    clr_hit,
  output logic                    px_sprite,
  output logic                    collide,
  output logic                    busy
);
  localparam int KW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic [KW-1:0] LAST = KW'(NUM_SPR - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic               r_hs_d;
  logic [1:0]         r_state;
  logic [KW-1:0]      r_k;
  logic [ROW_W-1:0]   r_tgt_row;
  logic               r_rom_en;
  logic [ID_W+LH-1:0] r_rom_addr;
  logic               r_busy;
  logic               r_iss_vld;
  logic [KW-1:0]      r_iss_slot;
  logic               r_cap_vld;
  logic [KW-1:0]      r_cap_slot;
  logic               r_cap_hit;
  logic               r_collide;

  logic               w_trig;
  logic [1:0]         w_nxt_state;
  logic [KW-1:0]      w_nxt_k;
  logic               w_iss_vld;
  logic [KW-1:0]      w_iss_slot;
  logic [ROW_W-1:0]   w_iss_row;
  logic [ROW_W:0]     w_row_ext;
  logic [ROW_W:0]     w_top_ext;
  logic               w_iss_hit;
  logic [LH-1:0]      w_line;
  logic [NUM_SPR-1:0] w_p;
  logic               w_set;

  logic [COL_W-1:0]   w_x  [NUM_SPR];
  logic [ROW_W-1:0]   w_y  [NUM_SPR];
  logic [ID_W-1:0]    w_id [NUM_SPR];

  assign w_trig = r_hs_d && !hs;

  // The registered issue for slot k must be on the ROM port while the FSM sits at k,
  // so each cycle issues the slot the FSM moves to next (slot 0 straight off the trigger).
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_k     = r_k;
    w_iss_vld   = 1'b0;
    w_iss_slot  = '0;
    w_iss_row   = r_tgt_row;
    if (w_trig) begin
      w_nxt_state = FETCH;
      w_nxt_k     = '0;
      w_iss_vld   = 1'b1;
      w_iss_slot  = '0;
      w_iss_row   = row_addr;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_state = IDLE;
        end
        FETCH: begin
          if (r_k == LAST) begin
            w_nxt_state = DRAIN;
          end else begin
            w_nxt_k    = KW'(r_k + 1'b1);
            w_iss_vld  = 1'b1;
            w_iss_slot = KW'(r_k + 1'b1);
          end
        end
        DRAIN: begin
          w_nxt_state = IDLE;
        end
        default: begin
          w_nxt_state = IDLE;
        end
      endcase
    end
  end

  assign w_row_ext = {1'b0, w_iss_row};
  assign w_top_ext = {1'b0, w_y[w_iss_slot]};
  assign w_iss_hit = w_iss_vld && spr_en[w_iss_slot]
                     && (w_iss_row < ROW_W'(SCR_H))
                     && (w_row_ext >= w_top_ext)
                     && (w_row_ext < w_top_ext + (ROW_W+1)'(SPR_H));
  assign w_line    = w_iss_row[LH-1:0] - w_y[w_iss_slot][LH-1:0];

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_hs_d     <= 1'b1;
      r_state    <= IDLE;
      r_k        <= '0;
      r_tgt_row  <= '0;
      r_busy     <= 1'b0;
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
      r_iss_vld  <= 1'b0;
      r_iss_slot <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_slot <= '0;
      r_cap_hit  <= 1'b0;
    end else begin
      r_hs_d     <= hs;
      r_state    <= w_nxt_state;
      r_k        <= w_nxt_k;
      r_busy     <= (w_nxt_state != IDLE);
      r_tgt_row  <= w_trig ? row_addr : r_tgt_row;
      r_rom_en   <= w_iss_hit;
      r_rom_addr <= w_iss_hit ? {w_id[w_iss_slot], w_line} : '0;
      r_iss_vld  <= w_iss_vld;
      r_iss_slot <= w_iss_slot;
      // ROM data arrives one cycle after the read, so the capture trails the issue by one stage.
      r_cap_vld  <= r_iss_vld;
      r_cap_slot <= r_iss_slot;
      r_cap_hit  <= r_rom_en;
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_slot
    assign w_x[g]  = spr_x[COL_W*g +: COL_W];
    assign w_y[g]  = spr_y[ROW_W*g +: ROW_W];
    assign w_id[g] = spr_id[ID_W*g +: ID_W];

    sprite_slot #(
      .SPR_W(SPR_W)
    ) u_slot (
      .vga_clk   (vga_clk),
      .clrn      (clrn),
      .i_load    (r_cap_vld && (r_cap_slot == KW'(g))),
      .i_hit     (r_cap_hit),
      .i_rom_data(rom_data),
      .i_x       (w_x[g]),
      .i_col     (col_addr),
      .o_px      (w_p[g])
    );
  end

  // Slot 0 is the dinosaur; any other slot on the same pixel is an overlap.
  assign w_set = !rdn && w_p[0] && (|w_p[NUM_SPR-1:1]);

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      r_collide <= 1'b0;
    end else if (w_set) begin
      r_collide <= 1'b1;
    end else if (clr_hit) begin
      r_collide <= 1'b0;
    end
  end

  assign px_sprite = !rdn && (|w_p);
  assign rom_en    = r_rom_en;
  assign rom_addr  = r_rom_addr;
  assign busy      = r_busy;
  assign collide   = r_collide;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Randomized and directed bench for sprite_line_scheduler against a per-line
// behavioural model of slot hits, ROM fetches, pixels and the collision flag.
module tb_sprite_line_scheduler;
  import dino_pkg::*;

  localparam int N = 4;

  logic        vga_clk = 1'b0;
  logic        clrn, hs, rdn, clr_hit;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [3:0]  spr_en;
  logic [39:0] spr_x;
  logic [35:0] spr_y;
  logic [11:0] spr_id;
  logic        rom_en;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        px_sprite, collide, busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [128];

  int          m_x    [N];
  logic [15:0] m_mask [N];
  bit          m_coll;
  bit          exp_en   [N];
  int          exp_addr [N];

  logic        obs_en   [6];
  logic [6:0]  obs_addr [6];
  logic        obs_busy [6];
  logic        obs_px   [640];
  logic        obs_col  [640];
  bit          exp_px   [640];
  bit          exp_col  [640];

  always #20 vga_clk = ~vga_clk;

  always @(posedge vga_clk) begin
    if (rom_en) rom_data <= mem[rom_addr];
  end

  sprite_line_scheduler dut (
    .vga_clk  (vga_clk),
    .clrn     (clrn),
    .hs       (hs),
    .rdn      (rdn),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .spr_en   (spr_en),
    .spr_x    (spr_x),
    .spr_y    (spr_y),
    .spr_id   (spr_id),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .clr_hit  (clr_hit),
    .px_sprite(px_sprite),
    .collide  (collide),
    .busy     (busy)
  );

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_slot(input int k, input bit en, input int x, input int y, input int id);
    spr_en[k]          = en;
    spr_x[10*k +: 10]  = 10'(x);
    spr_y[9*k +: 9]    = 9'(y);
    spr_id[3*k +: 3]   = 3'(id);
  endtask

  // Model: a slot shows pixel c if c lies in its 16-wide window and that bitmap bit is set.
  function automatic bit model_p(int k, int c);
    int d;
    d = c - m_x[k];
    if (d < 0 || d >= SPR_W) return 1'b0;
    return m_mask[k][SPR_W-1-d];
  endfunction

  task automatic model_fetch(input int row);
    for (int k = 0; k < N; k++) begin
      int y;
      bit hit;
      y   = int'(spr_y[9*k +: 9]);
      hit = spr_en[k] && (row < SCR_H) && (row >= y) && (row < y + SPR_H);
      exp_en[k]   = hit;
      exp_addr[k] = hit ? (int'(spr_id[3*k +: 3]) * SPR_H + (row - y)) : 0;
      m_mask[k]   = hit ? mem[exp_addr[k]] : 16'h0000;
      m_x[k]      = int'(spr_x[10*k +: 10]);
    end
  endtask

  task automatic fetch_line(input int row);
    step();
    hs       = 1'b0;
    row_addr = 9'(row);
    rdn      = 1'b1;
    clr_hit  = 1'b0;
    col_addr = 10'd0;
    model_fetch(row);
    for (int i = 0; i < 6; i++) begin
      step();
      obs_en[i]   = rom_en;
      obs_addr[i] = rom_addr;
      obs_busy[i] = busy;
    end
  endtask

  task automatic sweep_line(input int chg_col, input int new_x0, input int clr_a, input int clr_b);
    step();
    hs = 1'b1;
    for (int c = 0; c < SCR_W; c++) begin
      bit ov;
      bit clr;
      step();
      col_addr = 10'(c);
      rdn      = 1'b0;
      clr      = (c == clr_a) || (c == clr_b);
      clr_hit  = clr;
      if (c == chg_col) spr_x[9:0] = 10'(new_x0);
      exp_px[c]  = model_p(0, c) || model_p(1, c) || model_p(2, c) || model_p(3, c);
      exp_col[c] = m_coll;
      ov = model_p(0, c) && (model_p(1, c) || model_p(2, c) || model_p(3, c));
      m_coll = ov ? 1'b1 : (clr ? 1'b0 : m_coll);
      #8;
      obs_px[c]  = px_sprite;
      obs_col[c] = collide;
    end
    step();
    rdn     = 1'b1;
    clr_hit = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; hs = 1'b1; rdn = 1'b0; clr_hit = 1'b0;
    row_addr = 9'd0; col_addr = 10'd100;
    spr_en = 4'b0000; spr_x = 40'd0; spr_y = 36'd0; spr_id = 12'd0;
    rom_data = 16'h0000;
    m_coll = 1'b0;
    for (int k = 0; k < N; k++) begin m_x[k] = 0; m_mask[k] = 16'h0000; end
    repeat (3) step();
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b want 0", rom_en); end
    checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL reset_collide got %b want 0", collide); end
    checks++; if (px_sprite !== 1'b0) begin errors++; $display("FAIL reset_px got %b want 0", px_sprite); end
    clrn = 1'b1;
    rdn  = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_basic();
    int ones;
    spr_en = 4'b0000;
    set_slot(0, 1'b1, 100, 200, int'(DINO_JUMP));
    mem[7'h25] = 16'h8001;
    fetch_line(205);
    checks++; if (obs_en[0] !== 1'b1 || obs_addr[0] !== 7'h25) begin
      errors++; $display("FAIL basic_issue got en=%b addr=%h want en=1 addr=25", obs_en[0], obs_addr[0]); end
    for (int i = 1; i < 6; i++) begin
      checks++; if (obs_en[i] !== 1'b0) begin errors++; $display("FAIL basic_idle_slot t+%0d got en=%b want 0", i+1, obs_en[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      checks++; if (obs_busy[i] !== (i < 5)) begin errors++; $display("FAIL basic_busy t+%0d got %b want %b", i+1, obs_busy[i], (i < 5)); end
    end
    sweep_line(-1, 0, -1, -1);
    ones = 0;
    for (int c = 0; c < SCR_W; c++) begin
      if (obs_px[c] === 1'b1) ones++;
      checks++; if (obs_px[c] !== exp_px[c]) begin errors++;
        if (errors < 30) $display("FAIL basic_px col=%0d got %b want %b", c, obs_px[c], exp_px[c]); end
    end
    checks++; if (obs_px[100] !== 1'b1 || obs_px[115] !== 1'b1 || ones != 2) begin
      errors++; $display("FAIL basic_cols got c100=%b c115=%b ones=%0d want 1 1 2", obs_px[100], obs_px[115], ones); end
    col_addr = 10'd100; rdn = 1'b1; #2;
    checks++; if (px_sprite !== 1'b0) begin errors++; $display("FAIL basic_rdn_gate got %b want 0", px_sprite); end
  endtask

  task automatic test_miss();
    int ones;
    spr_en = 4'b0000;
    set_slot(0, 1'b1, 100, 200, 1);
    set_slot(1, 1'b0, 50, 210, 3);
    fetch_line(216);
    for (int i = 0; i < 6; i++) begin
      checks++; if (obs_en[i] !== 1'b0 || obs_addr[i] !== 7'd0) begin
        errors++; $display("FAIL miss_rom t+%0d got en=%b addr=%h want 0 0", i+1, obs_en[i], obs_addr[i]); end
    end
    sweep_line(-1, 0, -1, -1);
    ones = 0;
    for (int c = 0; c < SCR_W; c++) if (obs_px[c] !== 1'b0) ones++;
    checks++; if (ones != 0) begin errors++; $display("FAIL miss_px got %0d lit cols want 0", ones); end
  endtask

  task automatic test_collide();
    spr_en = 4'b0000;
    set_slot(0, 1'b1, 100, 200, int'(DINO_RUN0));
    set_slot(1, 1'b1, 108, 200, int'(CACTUS_L));
    mem[0*16 + 3] = 16'hFFFF;
    mem[4*16 + 3] = 16'hFFFF;
    fetch_line(203);
    sweep_line(-1, 0, 112, 200);
    for (int c = 0; c < SCR_W; c++) begin
      checks++; if (obs_px[c] !== exp_px[c] || obs_col[c] !== exp_col[c]) begin errors++;
        if (errors < 30) $display("FAIL collide_line col=%0d got px=%b col=%b want px=%b col=%b",
                                  c, obs_px[c], obs_col[c], exp_px[c], exp_col[c]); end
    end
    checks++; if (obs_col[108] !== 1'b0 || obs_col[109] !== 1'b1) begin
      errors++; $display("FAIL collide_rise got c108=%b c109=%b want 0 1", obs_col[108], obs_col[109]); end
    checks++; if (obs_col[113] !== 1'b1) begin errors++; $display("FAIL collide_set_wins got %b want 1", obs_col[113]); end
    checks++; if (obs_col[199] !== 1'b1 || obs_col[201] !== 1'b0) begin
      errors++; $display("FAIL collide_clear got c199=%b c201=%b want 1 0", obs_col[199], obs_col[201]); end
  endtask

  task automatic test_right_edge();
    spr_en = 4'b0000;
    set_slot(2, 1'b1, 630, 100, int'(BIRD));
    mem[5*16 + 0] = 16'hFFFF;
    mem[5*16 + 1] = 16'hFFFF;
    fetch_line(100);
    sweep_line(-1, 0, -1, -1);
    for (int c = 620; c < SCR_W; c++) begin
      checks++; if (obs_px[c] !== (c >= 630)) begin errors++; $display("FAIL edge_px col=%0d got %b want %b", c, obs_px[c], (c >= 630)); end
    end
    fetch_line(101);
    sweep_line(-1, 0, -1, -1);
    for (int c = 0; c < SCR_W; c++) begin
      checks++; if (obs_px[c] !== exp_px[c]) begin errors++;
        if (errors < 30) $display("FAIL edge_next_px col=%0d got %b want %b", c, obs_px[c], exp_px[c]); end
    end
    for (int c = 0; c < 6; c++) begin
      checks++; if (obs_px[c] !== 1'b0) begin errors++; $display("FAIL edge_nowrap col=%0d got %b want 0", c, obs_px[c]); end
    end
  endtask

  task automatic test_reset_midfetch();
    int ones;
    spr_en = 4'b0000;
    set_slot(0, 1'b1, 100, 200, int'(DINO_RUN0));
    set_slot(1, 1'b1, 108, 200, int'(CACTUS_L));
    mem[0*16 + 4] = 16'hFFFF;
    mem[4*16 + 4] = 16'hFFFF;
    fetch_line(203);
    sweep_line(-1, 0, -1, -1);
    checks++; if (collide !== 1'b1) begin errors++; $display("FAIL midrst_pre_collide got %b want 1", collide); end
    step();
    hs = 1'b0; row_addr = 9'd204;
    step();
    step();
    clrn = 1'b0; hs = 1'b1; rdn = 1'b0; col_addr = 10'd100;
    #1;
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL midrst_rom_en got %b want 0", rom_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL midrst_collide got %b want 0", collide); end
    checks++; if (px_sprite !== 1'b0) begin errors++; $display("FAIL midrst_px got %b want 0", px_sprite); end
    m_coll = 1'b0;
    for (int k = 0; k < N; k++) begin m_x[k] = 0; m_mask[k] = 16'h0000; end
    step();
    clrn = 1'b1; rdn = 1'b1;
    step();
    sweep_line(-1, 0, -1, -1);
    ones = 0;
    for (int c = 0; c < SCR_W; c++) if (obs_px[c] !== 1'b0) ones++;
    checks++; if (ones != 0) begin errors++; $display("FAIL midrst_empty got %0d lit cols want 0", ones); end
    fetch_line(204);
    checks++; if (obs_en[0] !== 1'b1 || obs_addr[0] !== 7'h04) begin
      errors++; $display("FAIL midrst_refetch got en=%b addr=%h want 1 04", obs_en[0], obs_addr[0]); end
    sweep_line(-1, 0, -1, -1);
    checks++; if (obs_px[100] !== 1'b1 || obs_px[123] !== 1'b1) begin
      errors++; $display("FAIL midrst_redraw got c100=%b c123=%b want 1 1", obs_px[100], obs_px[123]); end
  endtask

  task automatic test_mid_line_change();
    spr_en = 4'b0000;
    set_slot(0, 1'b1, 100, 200, int'(DINO_RUN0));
    mem[0*16 + 5] = 16'hFFFF;
    mem[0*16 + 6] = 16'hFFFF;
    fetch_line(205);
    sweep_line(20, 300, -1, -1);
    checks++; if (obs_px[100] !== 1'b1 || obs_px[115] !== 1'b1 || obs_px[300] !== 1'b0) begin
      errors++; $display("FAIL midline_old got c100=%b c115=%b c300=%b want 1 1 0", obs_px[100], obs_px[115], obs_px[300]); end
    fetch_line(206);
    sweep_line(-1, 0, -1, -1);
    checks++; if (obs_px[100] !== 1'b0 || obs_px[300] !== 1'b1 || obs_px[315] !== 1'b1) begin
      errors++; $display("FAIL midline_new got c100=%b c300=%b c315=%b want 0 1 1", obs_px[100], obs_px[300], obs_px[315]); end
  endtask

  task automatic test_random();
    for (int ln = 0; ln < 10; ln++) begin
      int row;
      row = (ln % 4 == 3) ? int'($urandom_range(480, 511)) : int'($urandom_range(0, 479));
      for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
      for (int k = 0; k < N; k++) begin
        int y;
        y = ($urandom_range(0, 3) != 0) ? (row - int'($urandom_range(0, 20))) : int'($urandom_range(0, 511));
        if (y < 0) y = 0;
        set_slot(k, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 700)), y, int'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 1) == 1) spr_x[19:10] = spr_x[9:0] + 10'($urandom_range(0, 15));
      fetch_line(row);
      for (int k = 0; k < N; k++) begin
        checks++; if (obs_en[k] !== exp_en[k] || (exp_en[k] && obs_addr[k] !== 7'(exp_addr[k]))) begin errors++;
          $display("FAIL rand_issue line=%0d slot=%0d got en=%b addr=%h want en=%b addr=%h",
                   ln, k, obs_en[k], obs_addr[k], exp_en[k], 7'(exp_addr[k])); end
      end
      sweep_line(-1, 0, int'($urandom_range(0, 639)), -1);
      for (int c = 0; c < SCR_W; c++) begin
        checks++; if (obs_px[c] !== exp_px[c] || obs_col[c] !== exp_col[c]) begin errors++;
          if (errors < 30) $display("FAIL rand_line line=%0d col=%0d got px=%b col=%b want px=%b col=%b",
                                    ln, c, obs_px[c], obs_col[c], exp_px[c], exp_col[c]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    test_reset();
    test_basic();
    test_miss();
    test_collide();
    test_right_edge();
    test_reset_midfetch();
    test_mid_line_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
